// File: rtl/atm_session_driver_if.sv
// Command/response and ATM-core pin bundle for atm_session_driver.
// slave: the driver itself; master: host plus core side.
interface atm_session_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_acc;
  logic [1:0]  cmd_pin;
  logic [3:0]  cmd_amount;
  logic [1:0]  accNumber;
  logic [1:0]  Pin;
  logic        card_inserted;
  logic        enter;
  logic        dep;
  logic        with_d;
  logic        mini_s;
  logic [3:0]  amount_in;
  logic [15:0] balance;
  logic        accountfound;
  logic        pinfound;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_balance;

  modport slave (
    input  cmd_valid, cmd_op, cmd_acc,
    input  cmd_pin, cmd_amount,
    input  balance, accountfound, pinfound,
    output cmd_ready,
    output accNumber, Pin, card_inserted,
    output enter, dep, with_d, mini_s,
    output amount_in,
    output rsp_valid, rsp_status, rsp_balance
  );

  modport master (
    output cmd_valid, cmd_op, cmd_acc,
    output cmd_pin, cmd_amount,
    output balance, accountfound, pinfound,
    input  cmd_ready,
    input  accNumber, Pin, card_inserted,
    input  enter, dep, with_d, mini_s,
    input  amount_in,
    input  rsp_valid, rsp_status, rsp_balance
  );
endinterface

// File: rtl/atm_session_driver.sv
// ATM session driver: replays one host command into the ATM core.
// Optional balance cross-check: define ATM_DRV_BAL_CHECK_EN.
module atm_session_driver #(
  parameter int HOLD_CYCLES   = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int WAIT_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 2
`ifdef ATM_DRV_BAL_CHECK_EN
  ,
  parameter int DEP_LIMIT     = 10
`endif
) (
  input logic clk,
  input logic reset,
  atm_session_driver_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACC,
    S_CARD,
    S_CHK_ACC,
    S_PIN,
    S_CHK_PIN,
    S_OP,
    S_AMT,
    S_GAP,
    S_SETTLE,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_NO_ACC = 2'd1;
  localparam logic [1:0] ST_PIN    = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] SETL_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  state_t      nxt_q, nxt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  acc_q, acc_d;
  logic [1:0]  pin_q, pin_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] rbal_q, rbal_d;
  logic [1:0]  settle_st;

  logic hold_done;
  logic gap_done;
  logic wait_done;
  logic setl_done;

  assign hold_done = (cnt_q == HOLD_LAST);
  assign gap_done  = (cnt_q == GAP_LAST);
  assign wait_done = (cnt_q == WAIT_LAST);
  assign setl_done = (cnt_q == SETL_LAST);

`ifdef ATM_DRV_BAL_CHECK_EN
  logic [15:0] bal_pre_q, bal_pre_d;
  logic [15:0] exp_bal;
  logic [15:0] amt16;

  assign amt16 = {12'd0, amt_q};

  // Expected post-transaction balance from the pre-op snapshot.
  always_comb begin
    exp_bal = bal_pre_q;
    unique case (op_q)
      2'd0:
        if (amt16 <= 16'(DEP_LIMIT))
          exp_bal = bal_pre_q + amt16;
      2'd1:
        if (amt16 <= bal_pre_q)
          exp_bal = bal_pre_q - amt16;
      default: exp_bal = bal_pre_q;
    endcase
  end

  assign settle_st =
    (bus.balance != exp_bal) ? 2'd3 : ST_OK;

  // Pre-op balance snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bal_pre_q <= '0;
    else        bal_pre_q <= bal_pre_d;
  end
`else
  assign settle_st = ST_OK;
`endif

  // State, counter and latched command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      nxt_q    <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      pin_q    <= '0;
      amt_q    <= '0;
      status_q <= '0;
      rbal_q   <= '0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      pin_q    <= pin_d;
      amt_q    <= amt_d;
      status_q <= status_d;
      rbal_q   <= rbal_d;
    end
  end

  // Session sequencing: hold phases, gaps, waits, settle, respond.
  always_comb begin
    state_d  = state_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    amt_d    = amt_q;
    status_d = status_q;
    rbal_d   = rbal_q;
`ifdef ATM_DRV_BAL_CHECK_EN
    bal_pre_d = bal_pre_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          acc_d   = bus.cmd_acc;
          pin_d   = bus.cmd_pin;
          amt_d   = bus.cmd_amount;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC, S_CARD, S_PIN, S_OP: begin
        if (hold_done) begin
          cnt_d   = '0;
          state_d = S_GAP;
          unique case (state_q)
            S_ACC:   nxt_d = S_CARD;
            S_CARD:  nxt_d = S_CHK_ACC;
            S_PIN:   nxt_d = S_CHK_PIN;
            default: nxt_d = (op_q == 2'd2) ?
                             S_SETTLE : S_AMT;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_AMT: begin
        if (hold_done) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          cnt_d   = '0;
          state_d = nxt_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHK_ACC: begin
        if (bus.accountfound) begin
          cnt_d   = '0;
          state_d = S_PIN;
        end else if (wait_done) begin
          cnt_d    = '0;
          status_d = ST_NO_ACC;
          rbal_d   = bus.balance;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHK_PIN: begin
        if (bus.pinfound) begin
          cnt_d   = '0;
          state_d = (op_q == 2'd3) ? S_SETTLE : S_OP;
`ifdef ATM_DRV_BAL_CHECK_EN
          bal_pre_d = bus.balance;
`endif
        end else if (wait_done) begin
          cnt_d    = '0;
          status_d = ST_PIN;
          rbal_d   = bus.balance;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SETTLE: begin
        if (setl_done) begin
          cnt_d    = '0;
          rbal_d   = bus.balance;
          status_d = settle_st;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Core drives decoded from state; zero outside their own phase.
  always_comb begin
    bus.cmd_ready     = 1'b0;
    bus.accNumber     = '0;
    bus.Pin           = '0;
    bus.card_inserted = 1'b0;
    bus.enter         = 1'b0;
    bus.dep           = 1'b0;
    bus.with_d        = 1'b0;
    bus.mini_s        = 1'b0;
    bus.amount_in     = '0;
    bus.rsp_valid     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): bus.cmd_ready = 1'b1;
      (state_q == S_ACC): begin
        bus.accNumber = acc_q;
        bus.enter     = 1'b1;
      end
      (state_q == S_CARD): bus.card_inserted = 1'b1;
      (state_q == S_PIN): begin
        bus.Pin   = pin_q;
        bus.enter = 1'b1;
      end
      (state_q == S_OP): begin
        bus.dep    = (op_q == 2'd0);
        bus.with_d = (op_q == 2'd1);
        bus.mini_s = (op_q == 2'd2);
      end
      (state_q == S_AMT): begin
        bus.enter     = 1'b1;
        bus.amount_in = amt_q;
      end
      (state_q == S_RESP): bus.rsp_valid = 1'b1;
      default: bus.cmd_ready = 1'b0;
    endcase
  end

  assign bus.rsp_status  = status_q;
  assign bus.rsp_balance = rbal_q;

endmodule

// File: doc/atm_session_driver.md
Name: atm_session_driver

Overview:
- Initiator-side front panel for the ATM FSM core. It accepts one high-level transaction command: deposit, withdraw, mini statement or balance inquiry.
- It replays the full customer pin sequence into the core: account/enter, card insert, PIN/enter, operation strobe, amount/enter.
- It watches accountfound/pinfound/balance and returns a single status+balance response.
- It sits between the host/command logic and the atm core, replacing hand-written stimulus sequences.

Parameters:
- HOLD_CYCLES, 2, clocks each drive phase (acc, card, pin, op strobe, amount) is held.
- GAP_CYCLES, 1, idle clocks (all drives low) between phases.
- WAIT_CYCLES, 4, max clocks to wait for accountfound / pinfound before failing.
- SETTLE_CYCLES, 2, clocks after the last phase before balance is sampled.
- DEP_LIMIT, 10, largest deposit the core accepts (used only by the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=deposit, 1=withdraw, 2=mini statement, 3=inquiry
- cmd_acc  in  2  account number
- cmd_pin  in  2  PIN
- cmd_amount  in  4  transaction amount
- accNumber  out  2  to core
- Pin  out  2  to core
- card_inserted  out  1  to core
- enter  out  1  to core
- dep  out  1  to core
- with_d  out  1  to core
- mini_s  out  1  to core
- amount_in  out  4  to core
- balance  in  16  from core
- accountfound  in  1  from core
- pinfound  in  1  from core
- rsp_valid  out  1  one-cycle response strobe
- rsp_status  out  2  0=OK, 1=NO_ACCOUNT, 2=PIN_FAIL, 3=MISMATCH
- rsp_balance  out  16  balance sampled at end of session

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0 except cmd_ready=1. Latched command fields and counters are cleared. A reset mid-session drops every core drive immediately; no response is issued.
- Accept: cmd_valid&&cmd_ready in IDLE latches cmd_* and enters ACC on the next clock. cmd_ready=0 from then until back in IDLE.
- Phase timing: each drive phase lasts exactly HOLD_CYCLES and is followed by GAP_CYCLES with all core drives 0. Outside its own phase every core drive (including amount_in, Pin, accNumber) is 0.
- ACC: accNumber=acc, enter=1.
- CARD: card_inserted=1.
- CHK_ACC: up to WAIT_CYCLES; accountfound=1 on any cycle -> PIN; otherwise status=NO_ACCOUNT -> RESP.
- PIN: Pin=pin, enter=1.
- CHK_PIN: up to WAIT_CYCLES; pinfound=1 -> OP; otherwise status=PIN_FAIL -> RESP. There is a single attempt per command; repeated attempts are issued as new commands.
- OP:
  - op0 drives dep=1, op1 drives with_d=1, op2 drives mini_s=1.
  - op3 skips OP and AMT and goes directly to SETTLE.
  - balance is captured into bal_pre on OP entry.
- AMT: ops 0/1 only. enter=1, amount_in=amount. op2 skips AMT.
- SETTLE: SETTLE_CYCLES idle, then rsp_balance<=balance, status=OK -> RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_status/rsp_balance hold until the next RESP. Then IDLE.
- Latency, zero-wait full deposit: 5*HOLD + 4*GAP + 1(CHK_ACC) + 1(CHK_PIN) + SETTLE + 1 clocks from accept to rsp_valid. With defaults this is 19.
- Both accountfound and pinfound high in CHK_ACC: only accountfound is considered.
- cmd_valid during a session is ignored, not queued.

Optional Feature:
- Macro: ATM_DRV_BAL_CHECK_EN.
- Defined: in SETTLE, compute the 16-bit expected balance:
  - op0: bal_pre+amount if amount<=DEP_LIMIT, else bal_pre.
  - op1: bal_pre-amount if amount<=bal_pre, else bal_pre.
  - op2/op3: bal_pre.
  - If sampled balance != expected, rsp_status=3 (MISMATCH); otherwise 0.
- Undefined: no comparison is made, status 3 is never produced, and the bal_pre register is removed.

Test Plan:
- Reset mid-PIN phase (Pin=1, enter=1) -> all drives 0 within same cycle, cmd_ready=1, no rsp_valid.
- Deposit acc=1 pin=1 amt=2, core balance 0->2 -> dep high 2 clocks, enter+amount_in=2 high 2 clocks, rsp_valid 19 clocks after accept, status 0, rsp_balance=2.
- Wrong PIN (pin=3, pinfound never asserts) -> after 4 CHK_PIN clocks, status 2, no dep/with_d/mini_s pulse.
- accountfound held 0 -> status 1 after 4 CHK_ACC clocks, Pin never driven.
- Mini statement with balance=5 -> mini_s 2 clocks, amount_in stays 0, status 0, rsp_balance=5.
- With ATM_DRV_BAL_CHECK_EN: withdraw amt=4 from balance 3, core leaves 3 -> status 0. Deposit amt=11 where core wrongly yields 14 -> status 3.
